// File: rtl/slave_in_pkg.sv
// Shared definitions for the slave port receive half (and its transmit half).
package slave_in_pkg;

  // Default widths.
  localparam int ADDR_LEN_D  = 12;
  localparam int DATA_LEN_D  = 8;
  localparam int BURST_LEN_D = 12;

  // Receive FSM states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HEADER    = 3'd1,
    ST_DATA      = 3'd2,
    ST_WRITE     = 3'd3,
    ST_READ_WAIT = 3'd4
  } state_e;

  // Transaction direction, also used by the transmit half.
  typedef enum logic {
    DIR_WR = 1'b0,
    DIR_RD = 1'b1
  } dir_e;

endpackage

// File: rtl/slave_in_serial_shift_rx.sv
// LSB-first serial-to-parallel shifter with a bit counter.
// o_word is the value the register holds after the current bit is shifted
// in, so the caller can latch a complete word on the o_done cycle. W >= 2.
module serial_shift_rx #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic          i_bit,
  output logic [W-1:0]  o_word,
  output logic [CW-1:0] o_cnt,
  output logic          o_done
);

  logic [W-1:0]  r_sr;
  logic [CW-1:0] r_cnt;

  assign o_word = {i_bit, r_sr[W-1:1]};
  assign o_done = i_en && (r_cnt == CW'(W - 1));
  assign o_cnt  = r_cnt;

  // Shift an accepted bit in; counter rewinds after the last bit of a word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      r_sr  <= o_word;
      r_cnt <= o_done ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/slave_in.sv
// Slave port receive half: deserialises header and write data from the
// master, issues write strobes with auto-incrementing address, or hands a
// read request to the transmit half.
module slave_in
  import slave_in_pkg::*;
#(
  parameter int ADDR_LEN  = ADDR_LEN_D,
  parameter int DATA_LEN  = DATA_LEN_D,
  parameter int BURST_LEN = BURST_LEN_D
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 slave_sel,
  input  logic                 write_en,
  input  logic                 read_en,
  input  logic                 master_valid,
  input  logic                 tx_address,
  input  logic                 tx_burst_number,
  input  logic                 tx_data,
  input  logic                 tx_done,
  input  logic                 rd_done,
  output logic                 slave_ready,
  output logic                 mem_wr_en,
  output logic [ADDR_LEN-1:0]  mem_addr,
  output logic [DATA_LEN-1:0]  mem_wdata,
  output logic                 rd_req,
  output logic [BURST_LEN-1:0] rd_burst,
  output logic                 rx_done,
  output logic                 abort
);

  localparam int HCW = $clog2(ADDR_LEN + 1);
  localparam int DCW = $clog2(DATA_LEN + 1);
  localparam logic [HCW-1:0] BURST_CNT = HCW'(BURST_LEN);

  state_e               r_state, w_state_nxt;
  dir_e                 r_dir;
  logic [ADDR_LEN-1:0]  r_addr;
  logic [DATA_LEN-1:0]  r_wdata;
  logic [BURST_LEN-1:0] r_burst_sr;
  logic [BURST_LEN-1:0] r_burst;
  logic [BURST_LEN-1:0] r_wcnt;
  logic                 r_rd_req;

  logic                 w_ready_st, w_acc, w_active, w_last_wr, w_abort;
  logic                 w_start, w_clr, w_hdr_en, w_dat_en, w_hdr_done, w_dat_done;
  logic                 w_burst_shift, w_wr, w_rxd;
  logic [ADDR_LEN-1:0]  w_hdr_word;
  logic [DATA_LEN-1:0]  w_dat_word;
  logic [HCW-1:0]       w_hdr_cnt;
  logic [DCW-1:0]       w_dat_cnt;
  logic [BURST_LEN-1:0] w_burst_nxt, w_burst_fin, w_burst_eff;
  logic                 w_unused_cnt;

  // Bit-level handshake: ready only while shifting or idle.
  assign w_ready_st = (r_state == ST_IDLE) || (r_state == ST_HEADER) ||
                      (r_state == ST_DATA);
  assign w_acc      = master_valid && w_ready_st;
  assign w_start    = (r_state == ST_IDLE) && slave_sel && (write_en ^ read_en);
  assign w_clr      = (r_state == ST_IDLE);

  // Final word of a burst: tx_done in this cycle is a normal finish.
  assign w_last_wr  = (r_state == ST_WRITE) &&
                      (BURST_LEN'(r_wcnt + 1'b1) == r_burst);
  assign w_active   = (r_state == ST_HEADER) || (r_state == ST_DATA) ||
                      (r_state == ST_WRITE);
  assign w_abort    = w_active && (!slave_sel || (tx_done && !w_last_wr));

  assign w_hdr_en   = (r_state == ST_HEADER) && w_acc && !w_abort;
  assign w_dat_en   = (r_state == ST_DATA) && w_acc && !w_abort;

  // Burst count rides on the first BURST_LEN header bits.
  assign w_burst_shift = w_hdr_en && (w_hdr_cnt < BURST_CNT);
  assign w_burst_nxt   = {tx_burst_number, r_burst_sr[BURST_LEN-1:1]};
  assign w_burst_fin   = w_burst_shift ? w_burst_nxt : r_burst_sr;
  assign w_burst_eff   = (w_burst_fin == '0) ? BURST_LEN'(1) : w_burst_fin;

  assign w_unused_cnt  = ^w_dat_cnt;

  serial_shift_rx #(.W(ADDR_LEN), .CW(HCW)) u_hdr (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_clr),
    .i_en   (w_hdr_en),
    .i_bit  (tx_address),
    .o_word (w_hdr_word),
    .o_cnt  (w_hdr_cnt),
    .o_done (w_hdr_done)
  );

  serial_shift_rx #(.W(DATA_LEN), .CW(DCW)) u_dat (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_clr),
    .i_en   (w_dat_en),
    .i_bit  (tx_data),
    .o_word (w_dat_word),
    .o_cnt  (w_dat_cnt),
    .o_done (w_dat_done)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_rxd       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = ST_HEADER;
      end
      ST_HEADER: begin
        if (w_abort)         w_state_nxt = ST_IDLE;
        else if (w_hdr_done) w_state_nxt = (r_dir == DIR_RD) ? ST_READ_WAIT : ST_DATA;
      end
      ST_DATA: begin
        if (w_abort)         w_state_nxt = ST_IDLE;
        else if (w_dat_done) w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_wr = 1'b1;
          if (w_last_wr) begin
            w_rxd       = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
      end
      ST_READ_WAIT: begin
        if (rd_done) begin
          w_rxd       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: direction, header capture, write data, address/word counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dir      <= DIR_WR;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_burst_sr <= '0;
      r_burst    <= '0;
      r_wcnt     <= '0;
      r_rd_req   <= 1'b0;
    end else begin
      r_rd_req <= 1'b0;
      if (w_start) begin
        r_dir      <= read_en ? DIR_RD : DIR_WR;
        r_burst_sr <= '0;
      end
      if (w_burst_shift) r_burst_sr <= w_burst_nxt;
      if (w_hdr_done) begin
        r_addr   <= w_hdr_word;
        r_burst  <= w_burst_eff;
        r_wcnt   <= '0;
        r_rd_req <= (r_dir == DIR_RD);
      end
      if (w_dat_done) r_wdata <= w_dat_word;
      if (w_wr) begin
        r_addr <= r_addr + 1'b1;
        r_wcnt <= r_wcnt + 1'b1;
      end
    end
  end

  // Ready is forced low while reset is held so every output reads 0.
  assign slave_ready = w_ready_st && reset;
  assign mem_wr_en   = w_wr;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign rd_req      = r_rd_req;
  assign rd_burst    = r_burst;
  assign rx_done     = w_rxd;
  assign abort       = w_abort;

endmodule

// File: tb/tb_slave_in.sv
// Directed bench for slave_in: writes, bursts, gapped valid, read, abort, reset.
module tb_slave_in;

  logic        clk = 1'b0;
  logic        reset;
  logic        slave_sel, write_en, read_en, master_valid;
  logic        tx_address, tx_burst_number, tx_data, tx_done, rd_done;
  logic        slave_ready, mem_wr_en, rd_req, rx_done, abort;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [11:0] rd_burst;

  int checks   = 0;
  int failures = 0;

  // Event log written by the monitor, read by the directed steps.
  int          wr_cnt = 0, rdy_lo = 0, rx_cnt = 0, ab_cnt = 0, rq_cnt = 0;
  logic [11:0] wa [0:63];
  logic [7:0]  wd [0:63];
  int          b_wr, b_rdy, b_rx, b_ab, b_rq;

  slave_in dut (
    .clk(clk), .reset(reset), .slave_sel(slave_sel), .write_en(write_en),
    .read_en(read_en), .master_valid(master_valid), .tx_address(tx_address),
    .tx_burst_number(tx_burst_number), .tx_data(tx_data), .tx_done(tx_done),
    .rd_done(rd_done), .slave_ready(slave_ready), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .rd_req(rd_req),
    .rd_burst(rd_burst), .rx_done(rx_done), .abort(abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      if (mem_wr_en) begin
        wa[wr_cnt[5:0]] <= mem_addr;
        wd[wr_cnt[5:0]] <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end
      if (!slave_ready) rdy_lo <= rdy_lo + 1;
      if (rx_done)      rx_cnt <= rx_cnt + 1;
      if (abort)        ab_cnt <= ab_cnt + 1;
      if (rd_req)       rq_cnt <= rq_cnt + 1;
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap;
    b_wr = wr_cnt; b_rdy = rdy_lo; b_rx = rx_cnt; b_ab = ab_cnt; b_rq = rq_cnt;
  endtask

  task automatic start(input logic rd);
    slave_sel = 1'b1; write_en = !rd; read_en = rd;
    tick;
    write_en = 1'b0; read_en = 1'b0;
  endtask

  // Optional idle cycle with inverted junk before each bit.
  task automatic send_hdr(input logic [11:0] a, input logic [11:0] b, input bit gap);
    for (int i = 0; i < 12; i++) begin
      if (gap) begin
        master_valid = 1'b0; tx_address = ~a[i]; tx_burst_number = ~b[i]; tick;
      end
      master_valid = 1'b1; tx_address = a[i]; tx_burst_number = b[i]; tick;
    end
    master_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d, input bit gap, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (gap) begin
        master_valid = 1'b0; tx_data = ~d[i]; tick;
      end
      master_valid = 1'b1; tx_data = d[i]; tick;
    end
    master_valid = 1'b0;
  endtask

  task automatic single_write(input bit gap);
    snap;
    start(1'b0);
    send_hdr(12'h0A5, 12'd1, gap);
    send_word(8'h3C, gap, 8);
    @(negedge clk);
    chk("sw_wr_en",  {31'd0, mem_wr_en}, 32'd1);
    chk("sw_addr",   {20'd0, mem_addr},  32'h0A5);
    chk("sw_wdata",  {24'd0, mem_wdata}, 32'h3C);
    chk("sw_rxdone", {31'd0, rx_done},   32'd1);
    chk("sw_ready",  {31'd0, slave_ready}, 32'd0);
    tick;
    @(negedge clk);
    chk("sw_idle_ready", {31'd0, slave_ready}, 32'd1);
    chk("sw_idle_wr",    {31'd0, mem_wr_en},   32'd0);
    tick;
    chk("sw_count", wr_cnt - b_wr, 32'd1);
    chk("sw_abort", ab_cnt - b_ab, 32'd0);
  endtask

  initial begin
    reset = 1'b0; slave_sel = 1'b0; write_en = 1'b0; read_en = 1'b0;
    master_valid = 1'b0; tx_address = 1'b0; tx_burst_number = 1'b0;
    tx_data = 1'b0; tx_done = 1'b0; rd_done = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, slave_ready}, 32'd0);
    chk("rst_outs", {20'd0, mem_wr_en, rd_req, rx_done, abort, mem_addr, mem_wdata, rd_burst} , 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'd0, slave_ready}, 32'd1);
    tick;

    // Single write, continuous valid, then the same with gapped valid
    single_write(1'b0);
    single_write(1'b1);

    // Burst of 3 wrapping the address space
    snap;
    start(1'b0);
    send_hdr(12'hFFE, 12'd3, 1'b0);
    send_word(8'h11, 1'b0, 8); tick;
    send_word(8'h22, 1'b0, 8); tick;
    send_word(8'h33, 1'b0, 8); tick;
    tick;
    chk("bw_count", wr_cnt - b_wr, 32'd3);
    chk("bw_a0", {20'd0, wa[b_wr[5:0]]},       32'hFFE);
    chk("bw_a1", {20'd0, wa[6'(b_wr + 1)]},    32'hFFF);
    chk("bw_a2", {20'd0, wa[6'(b_wr + 2)]},    32'h000);
    chk("bw_d0", {24'd0, wd[b_wr[5:0]]},       32'h11);
    chk("bw_d2", {24'd0, wd[6'(b_wr + 2)]},    32'h33);
    chk("bw_rdy_lo", rdy_lo - b_rdy, 32'd3);
    chk("bw_rx", rx_cnt - b_rx, 32'd1);

    // Both directions requested: stays idle, dropping select is no abort
    snap;
    slave_sel = 1'b1; write_en = 1'b1; read_en = 1'b1; tick;
    write_en = 1'b0; read_en = 1'b0; slave_sel = 1'b0;
    @(negedge clk);
    chk("both_no_abort", {31'd0, abort}, 32'd0);
    tick;

    // Read: request after header, held off until rd_done
    snap;
    start(1'b1);
    send_hdr(12'h100, 12'd4, 1'b0);
    @(negedge clk);
    chk("rd_req",   {31'd0, rd_req},      32'd1);
    chk("rd_addr",  {20'd0, mem_addr},    32'h100);
    chk("rd_burst", {20'd0, rd_burst},    32'd4);
    chk("rd_ready", {31'd0, slave_ready}, 32'd0);
    tick;
    slave_sel = 1'b0;
    @(negedge clk);
    chk("rd_req_pulse", {31'd0, rd_req}, 32'd0);
    chk("rd_sel_ignored", {30'd0, abort, slave_ready}, 32'd0);
    tick; tick;
    rd_done = 1'b1;
    @(negedge clk);
    chk("rd_rxdone", {31'd0, rx_done}, 32'd1);
    tick;
    rd_done = 1'b0;
    @(negedge clk);
    chk("rd_idle", {30'd0, slave_ready, rx_done}, 32'd2);
    chk("rd_no_write", wr_cnt - b_wr, 32'd0);
    chk("rd_req_count", rq_cnt - b_rq, 32'd1);
    tick;

    // Abort mid second word of a 2-word burst
    snap;
    start(1'b0);
    send_hdr(12'h020, 12'd2, 1'b0);
    send_word(8'hA1, 1'b0, 8); tick;
    send_word(8'hB2, 1'b0, 3);
    slave_sel = 1'b0;
    @(negedge clk);
    chk("ab_abort", {31'd0, abort},     32'd1);
    chk("ab_no_wr", {31'd0, mem_wr_en}, 32'd0);
    tick;
    @(negedge clk);
    chk("ab_idle", {30'd0, slave_ready, abort}, 32'd2);
    tick;
    chk("ab_count", wr_cnt - b_wr, 32'd1);
    chk("ab_a0", {20'd0, wa[b_wr[5:0]]}, 32'h020);
    chk("ab_d0", {24'd0, wd[b_wr[5:0]]}, 32'hA1);
    chk("ab_rx", rx_cnt - b_rx, 32'd0);

    // Reset in the middle of a data word
    snap;
    start(1'b0);
    send_hdr(12'h055, 12'd1, 1'b0);
    send_word(8'hFF, 1'b0, 4);
    reset = 1'b0;
    @(negedge clk);
    chk("mr_outs", {20'd0, slave_ready, mem_wr_en, rx_done, abort, mem_addr, mem_wdata}, 32'd0);
    tick;
    reset = 1'b1;
    send_word(8'hFF, 1'b0, 8);
    @(negedge clk);
    chk("mr_idle_ready", {31'd0, slave_ready}, 32'd1);
    tick;
    chk("mr_no_write", wr_cnt - b_wr, 32'd0);

    // Burst count 0 writes one word; tx_done on the final write is normal
    snap;
    start(1'b0);
    send_hdr(12'h7FF, 12'd0, 1'b0);
    send_word(8'h5A, 1'b0, 8);
    tx_done = 1'b1;
    @(negedge clk);
    chk("b0_wr", {31'd0, mem_wr_en},   32'd1);
    chk("b0_addr", {20'd0, mem_addr},  32'h7FF);
    chk("b0_data", {24'd0, mem_wdata}, 32'h5A);
    chk("b0_done", {30'd0, rx_done, abort}, 32'd2);
    tick;
    tx_done = 1'b0;
    @(negedge clk);
    chk("b0_idle", {31'd0, slave_ready}, 32'd1);
    tick; tick;
    chk("b0_count", wr_cnt - b_wr, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slave_in.md
Name: slave_in

Overview:
- Receive half of a slave port; sits directly downstream of the master port's serial transmit lines.
- Deserialises the header (address and burst count) and write data words bit-serially from the master.
- Issues one-cycle memory write strobes with an auto-incrementing address, or hands a read request to the slave's transmit half.
- Drives slave_ready back to the master as the per-bit flow-control handshake.

Parameters:
ADDR_LEN, 12, address width in bits and header length in cycles
DATA_LEN, 8, data word width in bits
BURST_LEN, 12, burst-count width; must be <= ADDR_LEN

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
slave_sel  input  1  this slave is addressed by the bus
write_en  input  1  transaction is a write; sampled in IDLE
read_en  input  1  transaction is a read; sampled in IDLE
master_valid  input  1  serial bits on tx_* are valid this cycle
tx_address  input  1  serial address bit, LSB first
tx_burst_number  input  1  serial burst-count bit, LSB first
tx_data  input  1  serial write-data bit, LSB first
tx_done  input  1  master ends the transaction
rd_done  input  1  slave transmit half has finished the read burst
slave_ready  output  1  slave will accept a bit this cycle
mem_wr_en  output  1  one-cycle memory write strobe
mem_addr  output  ADDR_LEN  write address, or read start address
mem_wdata  output  DATA_LEN  write data
rd_req  output  1  one-cycle read request pulse
rd_burst  output  BURST_LEN  read word count
rx_done  output  1  one-cycle pulse when a transaction completes normally
abort  output  1  one-cycle pulse when a transaction is aborted

Behaviour:
- One clock; reset is asynchronous and active-low. While reset=0, all registers and outputs clear to 0, FSM goes to IDLE.
- Reset may occur at any point mid-operation; every state returns to IDLE and partially shifted bits are discarded.
- States: IDLE, HEADER, DATA, WRITE, READ_WAIT.
- IDLE:
  - slave_ready=1.
  - On slave_sel=1 with write_en xor read_en: latch the direction and go to HEADER.
  - If both write_en and read_en are 1: stay in IDLE with no outputs.
- Bit acceptance: a bit is taken only when master_valid && slave_ready. Cycles without that qualifier hold all counters.
- HEADER:
  - Lasts ADDR_LEN accepted bits.
  - Each accepted bit shifts tx_address into addr_sr (LSB first).
  - The first BURST_LEN accepted bits also shift tx_burst_number into burst_sr.
  - A burst count of 0 is treated as 1.
  - After the last header bit: write goes to DATA; read pulses rd_req for one cycle with mem_addr=addr, rd_burst=burst, then goes to READ_WAIT.
- DATA:
  - Accepts DATA_LEN bits of tx_data into a shift register.
  - After the last bit: go to WRITE.
- WRITE (single cycle):
  - slave_ready=0; mem_wr_en=1 with mem_addr and mem_wdata.
  - Then addr increments by 1, wrapping modulo 2^ADDR_LEN, and the word counter increments.
  - If word counter == burst: pulse rx_done and go to IDLE. Otherwise return to DATA.
- READ_WAIT:
  - slave_ready=0.
  - On rd_done: pulse rx_done and go to IDLE.
- Abort:
  - Trigger: in HEADER, DATA or WRITE, slave_sel=0 or tx_done=1 before the final word is written.
  - Response: pulse abort, suppress mem_wr_en that cycle, go to IDLE. Words already written remain.
  - tx_done in the same cycle as the final WRITE is normal completion (rx_done, no abort).
- In READ_WAIT, slave_sel is ignored; only rd_done exits.
- Latency: mem_wr_en fires exactly one cycle after the last accepted data bit. rd_req fires one cycle after the last header bit.
- Pulse outputs are held low in all other cycles.

Decomposition:
- Shared package: FSM state encoding, default width constants (ADDR_LEN/DATA_LEN/BURST_LEN), and the direction encoding (write=0, read=1) shared with the slave's transmit half.
- One natural sub-module: serial_shift_rx. It is a parameterised LSB-first shift register with a bit counter and a done pulse, instantiated for header and data.

Test Plan:
- Single write: addr=0x0A5, burst=1, data=0x3C, master_valid continuous -> after 12+8 bits, one mem_wr_en with mem_addr=0x0A5, mem_wdata=0x3C, rx_done in same cycle.
- Burst write: addr=0xFFE, burst=3, data 0x11/0x22/0x33 -> writes at 0xFFE, 0xFFF, 0x000; slave_ready=0 only in the 3 WRITE cycles.
- Gapped master_valid: deassert every other cycle during the same single write -> identical writes, just delayed; no extra bits captured.
- Read: addr=0x100, burst=4 -> rd_req one cycle after the 12th bit, mem_addr=0x100, rd_burst=4; slave_ready=0 until rd_done; rx_done on rd_done.
- Abort: burst=2 write, drop slave_sel after 3 bits of the second word -> exactly one mem_wr_en (first word), abort pulse, IDLE.
- Reset mid-DATA and burst=0 case: reset low during DATA -> all outputs 0, IDLE; burst=0 write -> exactly one word written.
